// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with registered, time-multiplexed digit scan output.
// Optional leading-zero blanking on bcd_out is enabled by defining BCD_SCAN_LEADING_BLANK_EN.
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  ripple,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         scan_idx;
    logic [4*DIGITS-1:0]   step_val;
    logic                  step_carry;
    logic                  carry;
    logic [3:0]            dig;
    logic [DIGITS-1:0]     sel_next;
    logic [3:0]            digit_next;
    logic [3:0]            bcd_next;

    // Carry/borrow chain: a digit only changes while a carry/borrow is still propagating.
    always_comb begin
        step_val = count;
        carry    = 1'b1;
        dig      = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = count[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (dig >= 4'd9) begin
                        step_val[4*i +: 4] = '0;
                        carry              = 1'b1;
                    end else begin
                        step_val[4*i +: 4] = dig + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                        carry              = 1'b1;
                    end else if (dig > 4'd9) begin
                        step_val[4*i +: 4] = 4'd9;
                        carry              = 1'b0;
                    end else begin
                        step_val[4*i +: 4] = dig - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        step_carry = carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            ripple <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            ripple <= 1'b0;
        end else if (en) begin
            count  <= step_val;
            ripple <= step_carry;
        end else begin
            ripple <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PRESC_LAST) begin
            presc    <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            presc    <= presc + 1'b1;
        end
    end

`ifdef BCD_SCAN_LEADING_BLANK_EN
    logic [DIGITS-1:0] zero_above;
    logic              blank_next;

    // zero_above[i]: digit i and every more-significant digit are zero.
    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            zero_above[i] = 1'b1;
            for (int unsigned j = i; j < DIGITS; j++) begin
                if (count[4*j +: 4] != 4'd0) begin
                    zero_above[i] = 1'b0;
                end
            end
        end
    end
`endif

    always_comb begin
        sel_next   = '0;
        digit_next = '0;
`ifdef BCD_SCAN_LEADING_BLANK_EN
        blank_next = 1'b0;
`endif
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                sel_next[i] = 1'b1;
                digit_next  = count[4*i +: 4];
`ifdef BCD_SCAN_LEADING_BLANK_EN
                blank_next  = (i != 0) && zero_above[i];
`endif
            end
        end
`ifdef BCD_SCAN_LEADING_BLANK_EN
        bcd_next = blank_next ? 4'hF : digit_next;
`else
        bcd_next = digit_next;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_sel <= DIGITS'(1);
            bcd_out   <= '0;
        end else begin
            digit_sel <= sel_next;
            bcd_out   <= bcd_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter: directed vector table, scan sequences, randomized run
// against a decimal-arithmetic reference model.
module tb_bcd_scan_counter;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int W  = 4 * D;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          up;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  count;
    logic          ripple;
    logic [3:0]    bcd_out;
    logic [D-1:0]  digit_sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  m_count;
    logic          m_ripple;
    int            m_edges;

    always #5 clk = ~clk;

    bcd_scan_counter #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .ripple    (ripple),
        .bcd_out   (bcd_out),
        .digit_sel (digit_sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bcd(input logic [W-1:0] v);
        for (int i = 0; i < D; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int to_int(input logic [W-1:0] v);
        int n = 0;
        for (int i = D - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Returns {wrap, next value}
    function automatic logic [W:0] step_model(input logic [W-1:0] v, input logic dir);
        int top = 10 ** D - 1;
        int n;
        logic c;
        logic [W-1:0] r;
        logic [3:0] d;
        if (is_bcd(v)) begin
            n = to_int(v);
            if (dir) return (n == top) ? {1'b1, to_bcd(0)} : {1'b0, to_bcd(n + 1)};
            else     return (n == 0)   ? {1'b1, to_bcd(top)} : {1'b0, to_bcd(n - 1)};
        end
        // raw (non-BCD) digits: apply the per-digit carry/borrow rules directly
        c = 1'b1;
        r = v;
        for (int i = 0; i < D; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (dir) begin
                    if (d >= 4'd9) r[4*i +: 4] = 4'd0;
                    else begin r[4*i +: 4] = d + 4'd1; c = 1'b0; end
                end else begin
                    if (d == 4'd0)     r[4*i +: 4] = 4'd9;
                    else if (d > 4'd9) begin r[4*i +: 4] = 4'd9; c = 1'b0; end
                    else begin r[4*i +: 4] = d - 4'd1; c = 1'b0; end
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [3:0] disp(input logic [W-1:0] v, input int idx);
`ifdef BCD_SCAN_LEADING_BLANK_EN
        if (idx > 0 && (v >> (4 * idx)) == '0) return 4'hF;
`endif
        return v[4*idx +: 4];
    endfunction

    // One clock edge: advance the model from the inputs, then compare all outputs.
    task automatic tick();
        int idx;
        logic [D-1:0] one;
        logic [D-1:0] e_sel;
        logic [3:0]   e_bcd;
        logic [W:0]   s;
        one   = 1;
        idx   = (m_edges / SD) % D;
        e_sel = one << idx;
        e_bcd = disp(m_count, idx);
        if (load) begin
            m_count  = load_val;
            m_ripple = 1'b0;
        end else if (en) begin
            s        = step_model(m_count, up);
            m_count  = s[W-1:0];
            m_ripple = s[W];
        end else begin
            m_ripple = 1'b0;
        end
        m_edges++;
        @(posedge clk);
        #1;
        check("model_count", count, m_count);
        check("model_ripple", ripple, m_ripple);
        check("model_bcd_out", bcd_out, e_bcd);
        check("model_digit_sel", digit_sel, e_sel);
    endtask

    task automatic drive(input logic l, input logic [W-1:0] lv, input logic e, input logic u);
        load     = l;
        load_val = lv;
        en       = e;
        up       = u;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("reset_count", count, 0);
        check("reset_ripple", ripple, 0);
        check("reset_bcd_out", bcd_out, 0);
        check("reset_digit_sel", digit_sel, 1);
        m_count  = '0;
        m_ripple = 1'b0;
        m_edges  = 0;
        rst = 1'b0;
        #1;
    endtask

    task automatic scan_check(input string name, input logic [W-1:0] val, input logic [W-1:0] codes);
        int k;
        logic [D-1:0] one;
        one = 1;
        do_reset();
        drive(1'b1, val, 1'b0, 1'b0);
        for (int n = 2; n <= SD * D + 2; n++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            if ((n - 2) % SD == 0) begin
                k = ((n - 2) / SD) % D;
                check({name, "_sel"}, digit_sel, one << k);
                check({name, "_bcd"}, bcd_out, codes[4*k +: 4]);
            end
        end
    endtask

    typedef struct {
        logic          ld;
        logic [W-1:0]  lv;
        logic          e;
        logic          u;
        logic [W-1:0]  ec;
        logic          er;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [W-1:0] rv;
        int r;

        vecs.push_back('{1'b1, 16'h0099, 1'b0, 1'b0, 16'h0099, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0});
        vecs.push_back('{1'b1, 16'h9999, 1'b0, 1'b0, 16'h9999, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9998, 1'b0});
        vecs.push_back('{1'b1, 16'h00A0, 1'b0, 1'b0, 16'h00A0, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0099, 1'b0});
        vecs.push_back('{1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1235, 1'b0});
        vecs.push_back('{1'b1, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{1'b1, 16'h00F9, 1'b0, 1'b0, 16'h00F9, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0});

        rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        #1;
        do_reset();

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            check("hold_after_reset", count, 0);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].u);
            check($sformatf("vec%0d_count", i), count, vecs[i].ec);
            check($sformatf("vec%0d_ripple", i), ripple, vecs[i].er);
        end

        // Reset mid-count and mid-scan takes effect without a clock edge
        drive(1'b1, 16'h5678, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);
        en = 1'b1;
        do_reset();
        en = 1'b0;

        scan_check("scan_4321", 16'h4321, 16'h4321);
`ifdef BCD_SCAN_LEADING_BLANK_EN
        scan_check("blank_0020", 16'h0020, 16'hFF20);
        scan_check("blank_0000", 16'h0000, 16'hFFF0);
`else
        scan_check("raw_0020", 16'h0020, 16'h0020);
        scan_check("raw_0000", 16'h0000, 16'h0000);
`endif

        do_reset();
        for (int t = 0; t < 800; t++) begin
            r = $urandom_range(0, 15);
            rv = '0;
            for (int i = 0; i < D; i++) rv[4*i +: 4] = 4'($urandom_range(0, 9));
            if (r == 1) rv = 16'h9999;
            if (r == 2) rv = 16'h0000;
            if (r == 3) rv = 16'($urandom);
            drive(r < 4, rv, $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
